// File: rtl/demux_tdm_16ch.sv
// Serial TDM to 16-channel demultiplexer: a frame is received into a shadow buffer and copied to the outputs only when it is complete.
// Outputs and ch/busy are registered; frame_valid and frame_err are one-cycle pulses after the deciding edge. There is no backpressure: every valid beat is taken.
module demux_tdm_16ch #(
    parameter int width  = 4,
    parameter int swidth = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              sof,
    input  logic [width-1:0]  din,
    output logic [width-1:0]  o0,
    output logic [width-1:0]  o1,
    output logic [width-1:0]  o2,
    output logic [width-1:0]  o3,
    output logic [width-1:0]  o4,
    output logic [width-1:0]  o5,
    output logic [width-1:0]  o6,
    output logic [width-1:0]  o7,
    output logic [width-1:0]  o8,
    output logic [width-1:0]  o9,
    output logic [width-1:0]  o10,
    output logic [width-1:0]  o11,
    output logic [width-1:0]  o12,
    output logic [width-1:0]  o13,
    output logic [width-1:0]  o14,
    output logic [width-1:0]  o15,
    output logic [swidth-1:0] ch,
    output logic              busy,
    output logic              frame_valid,
    output logic              frame_err
);

    localparam int NCH = 2 ** swidth;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [swidth-1:0] ch_q, ch_d;
    logic [width-1:0]  shadow_q [NCH];
    logic [width-1:0]  shadow_d [NCH];
    logic [width-1:0]  out_q    [NCH];
    logic [width-1:0]  out_d    [NCH];
    logic              fv_q, fv_d;
    logic              fe_q, fe_d;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && sof) begin
                    shadow_d[0] = din;
                    ch_d        = swidth'(1);
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (in_valid) begin
                    if (sof) begin
                        // early sof: restart the frame, outputs keep the last good frame
                        shadow_d[0] = din;
                        ch_d        = swidth'(1);
                        fe_d        = 1'b1;
                    end else begin
                        shadow_d[ch_q] = din;
                        ch_d           = ch_q + swidth'(1);
                        if (ch_q == swidth'(NCH - 1)) begin
                            for (int i = 0; i < NCH - 1; i++) begin
                                out_d[i] = shadow_q[i];
                            end
                            out_d[NCH-1] = din;
                            fv_d         = 1'b1;
                            state_d      = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    assign ch          = ch_q;
    assign busy        = (state_q == RECV);
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;

    assign o0  = out_q[0];
    assign o1  = out_q[1];
    assign o2  = out_q[2];
    assign o3  = out_q[3];
    assign o4  = out_q[4];
    assign o5  = out_q[5];
    assign o6  = out_q[6];
    assign o7  = out_q[7];
    assign o8  = out_q[8];
    assign o9  = out_q[9];
    assign o10 = out_q[10];
    assign o11 = out_q[11];
    assign o12 = out_q[12];
    assign o13 = out_q[13];
    assign o14 = out_q[14];
    assign o15 = out_q[15];

endmodule

// File: tb/tb_demux_tdm_16ch.sv
// Directed bench for demux_tdm_16ch: hand-computed frames, latencies and pulse counts.
module tb_demux_tdm_16ch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       sof = 1'b0;
    logic [3:0] din = 4'h0;
    logic [3:0] o [16];
    logic [3:0] ch;
    logic       busy, frame_valid, frame_err;
    logic [63:0] outs;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int busy_cnt = 0;

    always #5 clk = ~clk;

    demux_tdm_16ch #(.width(4), .swidth(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .din(din),
        .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]),
        .o4(o[4]), .o5(o[5]), .o6(o[6]), .o7(o[7]),
        .o8(o[8]), .o9(o[9]), .o10(o[10]), .o11(o[11]),
        .o12(o[12]), .o13(o[13]), .o14(o[14]), .o15(o[15]),
        .ch(ch), .busy(busy), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always_comb begin
        outs = '0;
        for (int i = 0; i < 16; i++) outs[i*4 +: 4] = o[i];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (frame_valid === 1'b1 || frame_err === 1'b1)
            chk("fv_fe_exclusive", {63'd0, frame_valid & frame_err}, 64'd0);
    end

    task automatic beat(input logic v, input logic s, input logic [3:0] d);
        @(negedge clk);
        in_valid = v;
        sof      = s;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] abcd(input int i);
        logic [15:0] p;
        p = 16'hDCBA;
        return p[(i % 4) * 4 +: 4];
    endfunction

    int t0, fv0, fe0, b0, t1;

    initial begin
        // reset state
        repeat (2) beat(0, 0, 4'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_outs", outs, 64'd0);
        chk("rst_ch", ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_fe", frame_err, 0);

        // beats without sof while idle are ignored
        fv0 = fv_cnt; fe0 = fe_cnt;
        repeat (5) beat(1, 0, 4'hA);
        chk("idle_ch", ch, 0);
        chk("idle_busy", busy, 0);
        chk("idle_outs", outs, 64'd0);
        beat(0, 0, 4'h0);
        chk("idle_pulses", fv_cnt + fe_cnt - fv0 - fe0, 0);

        // full continuous frame A,B,C,D,...
        fv0 = fv_cnt; b0 = busy_cnt; t0 = cyc;
        beat(1, 1, abcd(0));
        chk("full_ch1", ch, 1);
        chk("full_busy", busy, 1);
        for (int i = 1; i < 15; i++) beat(1, 0, abcd(i));
        chk("full_no_early_fv", frame_valid, 0);
        chk("full_no_partial", outs, 64'd0);
        beat(1, 0, abcd(15));
        chk("full_fv", frame_valid, 1);
        chk("full_latency", cyc - t0, 16);
        chk("full_outs", outs, 64'hDCBA_DCBA_DCBA_DCBA);
        chk("full_ch_wrap", ch, 0);
        chk("full_busy_low", busy, 0);
        beat(0, 0, 4'h0);
        chk("full_fv_one_cycle", frame_valid, 0);
        chk("full_fv_count", fv_cnt - fv0, 1);
        chk("full_busy_cycles", busy_cnt - b0, 15);

        // gapped frame: three idle cycles after beat 7
        t0 = cyc;
        beat(1, 1, abcd(0));
        for (int i = 1; i < 8; i++) beat(1, 0, abcd(i));
        for (int g = 0; g < 3; g++) begin
            beat(0, 0, 4'h5);
            chk("gap_ch_hold", ch, 8);
        end
        chk("gap_busy", busy, 1);
        for (int i = 8; i < 15; i++) beat(1, 0, abcd(i));
        chk("gap_no_early_fv", frame_valid, 0);
        beat(1, 0, abcd(15));
        chk("gap_fv", frame_valid, 1);
        chk("gap_latency", cyc - t0, 19);
        chk("gap_outs", outs, 64'hDCBA_DCBA_DCBA_DCBA);
        beat(0, 0, 4'h0);

        // early sof at beat 9 restarts the frame
        fv0 = fv_cnt; fe0 = fe_cnt;
        beat(1, 1, 4'h5);
        for (int i = 1; i < 9; i++) beat(1, 0, 4'h5);
        chk("esof_ch9", ch, 9);
        beat(1, 1, 4'hF);
        chk("esof_fe", frame_err, 1);
        chk("esof_no_fv", frame_valid, 0);
        chk("esof_ch", ch, 1);
        chk("esof_busy", busy, 1);
        chk("esof_outs_kept", outs, 64'hDCBA_DCBA_DCBA_DCBA);
        for (int i = 1; i < 16; i++) begin
            beat(1, 0, 4'(i));
            if (i == 1) chk("esof_fe_one_cycle", frame_err, 0);
        end
        chk("esof_fv", frame_valid, 1);
        chk("esof_outs", outs, 64'hFEDC_BA98_7654_321F);
        beat(0, 0, 4'h0);
        chk("esof_fe_count", fe_cnt - fe0, 1);
        chk("esof_fv_count", fv_cnt - fv0, 1);

        // back-to-back frames, E then B
        fv0 = fv_cnt;
        beat(1, 1, 4'hE);
        for (int i = 1; i < 16; i++) beat(1, 0, 4'hE);
        chk("b2b_fv1", frame_valid, 1);
        chk("b2b_outs1", outs, 64'hEEEE_EEEE_EEEE_EEEE);
        t1 = cyc;
        beat(1, 1, 4'hB);
        chk("b2b_sof_accepted", ch, 1);
        chk("b2b_busy", busy, 1);
        for (int i = 1; i < 16; i++) beat(1, 0, 4'hB);
        chk("b2b_fv2", frame_valid, 1);
        chk("b2b_spacing", cyc - t1, 16);
        chk("b2b_outs2", outs, 64'hBBBB_BBBB_BBBB_BBBB);
        beat(0, 0, 4'h0);
        chk("b2b_fv_count", fv_cnt - fv0, 2);

        // reset mid-frame at ch=6, then a frame of all C
        beat(1, 1, 4'h7);
        for (int i = 1; i < 6; i++) beat(1, 0, 4'h7);
        chk("mrst_ch6", ch, 6);
        fv0 = fv_cnt; fe0 = fe_cnt;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; sof = 1'b1; din = 4'h7;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; sof = 1'b0;
        @(posedge clk); #1;
        chk("mrst_outs", outs, 64'd0);
        chk("mrst_ch", ch, 0);
        chk("mrst_busy", busy, 0);
        beat(0, 0, 4'h0);
        chk("mrst_pulses", fv_cnt + fe_cnt - fv0 - fe0, 0);
        beat(1, 1, 4'hC);
        for (int i = 1; i < 16; i++) beat(1, 0, 4'hC);
        chk("mrst_fv", frame_valid, 1);
        chk("mrst_outs_c", outs, 64'hCCCC_CCCC_CCCC_CCCC);
        beat(0, 0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/demux_tdm_16ch.md
DEMUX_TDM_16CH -- requirements
Module: demux_tdm_16ch

Interface
REQ-001 Parameter: width, 4, bit width of each data word.
REQ-002 Parameter: swidth, 4, channel index width; the block SHALL support exactly 2**swidth = 16 channels.
REQ-003 Port: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  din carries a valid beat this cycle.
REQ-006 Port: sof  input  1  start of frame; meaningful only when in_valid=1.
REQ-007 Port: din  input  width  serial TDM data word for the current channel.
REQ-008 Port: o0..o15  output  width each  registered per-channel outputs from the last complete frame.
REQ-009 Port: ch  output  swidth  index of the channel that the next accepted beat will be written to.
REQ-010 Port: busy  output  1  high while a frame is partially received (state RECV).
REQ-011 Port: frame_valid  output  1  one-cycle pulse; o0..o15 were updated at the previous edge.
REQ-012 Port: frame_err  output  1  one-cycle pulse; the partial frame was aborted by an early sof.

Function
REQ-013 The FSM SHALL have two states, IDLE and RECV, and shall hold a 16-entry shadow buffer plus a 16-entry output buffer.
REQ-014 In IDLE with in_valid=1 and sof=1, the block SHALL write din to shadow[0], set ch to 1, and enter RECV.
REQ-015 In IDLE, beats with in_valid=1 and sof=0 SHALL be discarded with no state change; ch SHALL remain 0.
REQ-016 In RECV with in_valid=1 and sof=0, the block SHALL write din to shadow[ch] and increment ch by 1.
REQ-017 In RECV with in_valid=0, all state SHALL hold.
REQ-018 When a beat is accepted at ch=15, the block SHALL, at that same edge, load o0..o14 from shadow[0..14] and o15 from din, then:
- set frame_valid=1 for exactly the following cycle;
- wrap ch to 0;
- return to IDLE.
REQ-019 In RECV with in_valid=1 and sof=1 (at any ch, including 15), the block SHALL:
- discard the partial frame;
- write din to shadow[0] and set ch to 1;
- stay in RECV;
- pulse frame_err for one cycle;
- leave o0..o15 unchanged and not assert frame_valid.
REQ-020 o0..o15 SHALL change only on a completed frame (REQ-018); they SHALL never expose partial-frame data.
REQ-021 Back-to-back frames SHALL be accepted with zero idle cycles: a sof beat in the cycle after the final beat starts a new frame while frame_valid is high.
REQ-022 Latency: from the sof beat edge to frame_valid high SHALL be exactly 16 cycles when in_valid is held high; every in_valid=0 cycle inside the frame adds one cycle.
REQ-023 busy SHALL equal (state==RECV).
REQ-024 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL:
- enter IDLE, set ch=0 and busy=0;
- set frame_valid=0 and frame_err=0;
- clear o0..o15 and the shadow buffer to 0.
REQ-026 Reset SHALL take priority over all inputs, including mid-frame; an aborted frame SHALL produce neither frame_valid nor frame_err.

Verification
REQ-027 Full frame: sof plus 16 continuous beats A,B,C,D,A,B,C,D,... -> frame_valid pulses once, 16 cycles after the sof edge; o0=A, o1=B, o2=C, o3=D, ..., o15=D; busy high for 15 cycles.
REQ-028 Gapped frame: same data as REQ-027 with in_valid=0 for 3 cycles after beat 7 -> frame_valid at cycle 19; same outputs; ch holds 8 during the gap.
REQ-029 Early sof: sof at beat 0, then at beat 9 (din=F) -> frame_err pulses once; o* still hold the prior frame; the following 15 beats complete the frame with o0=F.
REQ-030 Back-to-back: two frames, all E then all B, with no gap -> two frame_valid pulses 16 cycles apart; o* read E at the first pulse and B at the second.
REQ-031 Reset mid-frame at ch=6, followed by a frame of all C -> after reset, o*=0 and ch=0 with no pulses; the following frame yields all o*=C.
REQ-032 Beats without sof while IDLE (5 beats, din=A) -> no state change, ch=0, busy=0, no pulses.
